// File: rtl/turn_if.sv
// Signal bundle between the turn sequencer and its surroundings
// (buttons, link frames, projectile engine, status display).
interface turn_if;
  logic       game_start;
  logic       first_player;
  logic       my_player;
  logic       btn_throw;
  logic       in_throw_flag;
  logic [4:0] in_power;
  logic       flight_done;
  logic       hit;
  logic       throw_start;
  logic [4:0] throw_power;
  logic       out_throw_flag;
  logic [4:0] out_power;
  logic       active_player;
  logic       charging;
  logic [7:0] turn;
  logic [3:0] hp1;
  logic [3:0] hp2;
  logic       game_over;
  logic       winner;

  modport master (
    output game_start, first_player, my_player, btn_throw,
           in_throw_flag, in_power, flight_done, hit,
    input  throw_start, throw_power, out_throw_flag, out_power,
           active_player, charging, turn, hp1, hp2, game_over, winner
  );

  modport slave (
    input  game_start, first_player, my_player, btn_throw,
           in_throw_flag, in_power, flight_done, hit,
    output throw_start, throw_power, out_throw_flag, out_power,
           active_player, charging, turn, hp1, hp2, game_over, winner
  );
endinterface

// File: rtl/turn_ctrl.sv
// Game-phase turn sequencer: alternates local and remote turns, launches
// throws, scores landings and stops when either player's HP reaches zero.
module turn_ctrl #(
  parameter int POWER_DIV      = 2_000_000,
  parameter int AIM_TIMEOUT    = 400_000_000,
  parameter int FLIGHT_TIMEOUT = 200_000_000,
  parameter int HP_INIT        = 3
) (
  input logic   clk40MHz,
  input logic   rst,
  turn_if.slave bus
);
  localparam int TMAX = (AIM_TIMEOUT > FLIGHT_TIMEOUT) ? AIM_TIMEOUT : FLIGHT_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int PW   = $clog2(POWER_DIV + 1);
  localparam logic [TW-1:0] AIM_LAST    = TW'(AIM_TIMEOUT - 1);
  localparam logic [TW-1:0] FLIGHT_LAST = TW'(FLIGHT_TIMEOUT - 1);
  localparam logic [PW-1:0] STEP_LAST   = PW'(POWER_DIV - 1);
  localparam logic [3:0]    HP_START    = 4'(HP_INIT);

  typedef enum logic [3:0] {
    WAIT_START, TURN_BEGIN, AIM_LOCAL, LAUNCH, WAIT_REMOTE,
    LAUNCH_REMOTE, FLIGHT, SWITCH, GAME_OVER
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [4:0]    power_reg, power_next;
  logic          armed_reg, armed_next;
  logic          charged_reg, charged_next;
  logic          flag_reg;
  logic [4:0]    flag_power_reg;
  logic          throw_start_reg, throw_start_next;
  logic [4:0]    throw_power_reg, throw_power_next;
  logic          out_flag_reg, out_flag_next;
  logic [4:0]    out_power_reg, out_power_next;
  logic          active_reg, active_next;
  logic          charging_reg, charging_next;
  logic [7:0]    turn_reg, turn_next;
  logic [3:0]    hp1_reg, hp1_next;
  logic [3:0]    hp2_reg, hp2_next;
  logic          game_over_reg, game_over_next;
  logic          winner_reg, winner_next;
  logic [4:0]    launch_power;

  // A zero-power frame is the link connect handshake, so never launch 0.
  assign launch_power = (power_reg == 5'd0) ? 5'd1 : power_reg;

  always_ff @(posedge clk40MHz or posedge rst) begin
    if (rst) begin
      state_reg       <= WAIT_START;
      timer_reg       <= '0;
      presc_reg       <= '0;
      power_reg       <= '0;
      armed_reg       <= 1'b0;
      charged_reg     <= 1'b0;
      flag_reg        <= 1'b0;
      flag_power_reg  <= '0;
      throw_start_reg <= 1'b0;
      throw_power_reg <= '0;
      out_flag_reg    <= 1'b0;
      out_power_reg   <= '0;
      active_reg      <= 1'b0;
      charging_reg    <= 1'b0;
      turn_reg        <= '0;
      hp1_reg         <= HP_START;
      hp2_reg         <= HP_START;
      game_over_reg   <= 1'b0;
      winner_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      presc_reg       <= presc_next;
      power_reg       <= power_next;
      armed_reg       <= armed_next;
      charged_reg     <= charged_next;
      flag_reg        <= bus.in_throw_flag;
      flag_power_reg  <= bus.in_power;
      throw_start_reg <= throw_start_next;
      throw_power_reg <= throw_power_next;
      out_flag_reg    <= out_flag_next;
      out_power_reg   <= out_power_next;
      active_reg      <= active_next;
      charging_reg    <= charging_next;
      turn_reg        <= turn_next;
      hp1_reg         <= hp1_next;
      hp2_reg         <= hp2_next;
      game_over_reg   <= game_over_next;
      winner_reg      <= winner_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    timer_next       = timer_reg;
    presc_next       = presc_reg;
    power_next       = power_reg;
    armed_next       = armed_reg;
    charged_next     = charged_reg;
    throw_power_next = throw_power_reg;
    active_next      = active_reg;
    charging_next    = 1'b0;
    turn_next        = turn_reg;
    hp1_next         = hp1_reg;
    hp2_next         = hp2_reg;
    winner_next      = winner_reg;

    case (state_reg)
      WAIT_START: begin
        if (bus.game_start) begin
          active_next = bus.first_player;
          state_next  = TURN_BEGIN;
        end
      end
      TURN_BEGIN: begin
        timer_next   = '0;
        presc_next   = '0;
        power_next   = '0;
        armed_next   = 1'b0;
        charged_next = 1'b0;
        state_next   = (active_reg == bus.my_player) ? AIM_LOCAL : WAIT_REMOTE;
      end
      AIM_LOCAL: begin
        timer_next = timer_reg + TW'(1);
        // A press held over from the previous turn must be released first.
        if (!bus.btn_throw) armed_next = 1'b1;
        if (timer_reg == AIM_LAST) begin
          state_next = LAUNCH;
        end else if (armed_reg && bus.btn_throw) begin
          charged_next  = 1'b1;
          charging_next = 1'b1;
          if (presc_reg == STEP_LAST) begin
            presc_next = '0;
            if (power_reg != 5'd31) power_next = power_reg + 5'd1;
          end else begin
            presc_next = presc_reg + PW'(1);
          end
        end else if (armed_reg && charged_reg && !bus.btn_throw) begin
          state_next = LAUNCH;
        end
        if (state_next == LAUNCH) throw_power_next = launch_power;
      end
      LAUNCH: begin
        timer_next = '0;
        state_next = FLIGHT;
      end
      WAIT_REMOTE: begin
        if (flag_reg && (flag_power_reg != 5'd0)) begin
          throw_power_next = flag_power_reg;
          state_next       = LAUNCH_REMOTE;
        end
      end
      LAUNCH_REMOTE: begin
        timer_next = '0;
        state_next = FLIGHT;
      end
      FLIGHT: begin
        timer_next = timer_reg + TW'(1);
        // A landing reported on the timeout cycle still counts.
        if (bus.flight_done) begin
          if (bus.hit) begin
            if (active_reg) begin
              if (hp1_reg != 4'd0) hp1_next = hp1_reg - 4'd1;
            end else begin
              if (hp2_reg != 4'd0) hp2_next = hp2_reg - 4'd1;
            end
          end
          state_next = SWITCH;
        end else if (timer_reg == FLIGHT_LAST) begin
          state_next = SWITCH;
        end
      end
      SWITCH: begin
        if ((hp1_reg == 4'd0) || (hp2_reg == 4'd0)) begin
          winner_next = active_reg;
          state_next  = GAME_OVER;
        end else begin
          turn_next   = turn_reg + 8'd1;
          active_next = ~active_reg;
          state_next  = TURN_BEGIN;
        end
      end
      GAME_OVER: state_next = GAME_OVER;
      default:   state_next = WAIT_START;
    endcase

    throw_start_next = (state_next == LAUNCH) || (state_next == LAUNCH_REMOTE);
    out_flag_next    = (state_next == LAUNCH);
    out_power_next   = (state_next == LAUNCH) ? launch_power : 5'd0;
    game_over_next   = (state_next == GAME_OVER);
  end

  assign bus.throw_start    = throw_start_reg;
  assign bus.throw_power    = throw_power_reg;
  assign bus.out_throw_flag = out_flag_reg;
  assign bus.out_power      = out_power_reg;
  assign bus.active_player  = active_reg;
  assign bus.charging       = charging_reg;
  assign bus.turn           = turn_reg;
  assign bus.hp1            = hp1_reg;
  assign bus.hp2            = hp2_reg;
  assign bus.game_over      = game_over_reg;
  assign bus.winner         = winner_reg;
endmodule
